// File: rtl/logic_unit_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin arbiter that shares one bitwise logic unit
//               (NOT/AND/OR/XOR) among N_REQ requesters. Optional per-requester
//               grant counters are enabled by defining ARB_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   op,
    input  logic [W*N_REQ-1:0]   a,
    input  logic [W*N_REQ-1:0]   b,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [W-1:0]         result,
    output logic                 busy
`ifdef ARB_STATS_EN
    ,
    output logic [16*N_REQ-1:0]  grant_cnt
`endif
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   r_win;
    logic [IDXW-1:0]   w_win;
    logic [IDXW-1:0]   w_cand;
    logic [IDXW-1:0]   w_rr_nxt;
    logic              w_found;
    logic              w_capture;
    logic [1:0]        r_op;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [1:0]        w_op_sel;
    logic [W-1:0]      w_a_sel;
    logic [W-1:0]      w_b_sel;
    logic [W-1:0]      w_alu;
    logic [N_REQ-1:0]  w_gnt_nxt;
    logic [N_REQ-1:0]  w_done_nxt;
    logic [W-1:0]      w_result_nxt;

    // First requester at or after the pointer, wrapping around, wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_cand  = r_rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = IDXW'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_op_sel = '0;
        w_a_sel  = '0;
        w_b_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == IDXW'(i)) begin
                w_op_sel = op[2*i +: 2];
                w_a_sel  = a[W*i +: W];
                w_b_sel  = b[W*i +: W];
            end
        end
    end

    always_comb begin
        w_alu = '0;
        case (r_op)
            2'b00:   w_alu = ~r_a;
            2'b01:   w_alu = r_a & r_b;
            2'b10:   w_alu = r_a | r_b;
            default: w_alu = r_a ^ r_b;
        endcase
    end

    assign w_capture = (r_state == ST_IDLE) && w_found;

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = gnt;
        w_done_nxt   = '0;
        w_result_nxt = result;
        w_rr_nxt     = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (w_found) begin
                    w_state_nxt = ST_EXEC;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                end
            end
            ST_EXEC: begin
                w_state_nxt  = ST_DONE;
                w_result_nxt = w_alu;
                w_done_nxt   = gnt;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_rr_nxt    = (r_win == IDXW'(N_REQ-1)) ? '0 : r_win + IDXW'(1);
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            gnt      <= '0;
            done     <= '0;
            result   <= '0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            gnt      <= w_gnt_nxt;
            done     <= w_done_nxt;
            result   <= w_result_nxt;
            busy     <= (w_state_nxt != ST_IDLE);
            // Operands are frozen at grant; later input changes are ignored.
            if (w_capture) begin
                r_win <= w_win;
                r_op  <= w_op_sel;
                r_a   <= w_a_sel;
                r_b   <= w_b_sel;
            end
        end
    end

`ifdef ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if ((r_state == ST_DONE) && (r_win == IDXW'(gi)) && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign grant_cnt[16*gi +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Directed bench for logic_unit_arbiter with a cycle-scheduled
//               reference model and a per-cycle output compare.
// Revision    : 1.0  initial release
// ============================================================================
module tb_logic_unit_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXC = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [2*N-1:0]   op;
    logic [W*N-1:0]   a;
    logic [W*N-1:0]   b;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic [W-1:0]     result;
    logic             busy;
`ifdef ARB_STATS_EN
    logic [16*N-1:0]  grant_cnt;
`endif

    logic_unit_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op     (op),
        .a      (a),
        .b      (b),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .busy   (busy)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;
    bit seen_rst = 1'b0;

    // Expected outputs for the interval following edge number e.
    logic [N-1:0] exp_gnt  [MAXC];
    logic [N-1:0] exp_done [MAXC];
    logic         exp_busy [MAXC];
    logic         res_set  [MAXC];
    logic [W-1:0] res_val  [MAXC];
    logic [W-1:0] cur_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, e);
        end
    endtask

    function automatic logic [W-1:0] lu(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            2'b00:   return ~x;
            2'b01:   return x & y;
            2'b10:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    // Reference model: schedules each operation's visible effects into the
    // future intervals it occupies, and tracks when the unit is free again.
    initial begin : model
        int free_at;
        int ptr;
        int win;
        logic [N-1:0] oh;
        free_at = 0;
        ptr     = 0;
        for (int i = 0; i < MAXC; i++) begin
            exp_gnt[i] = '0; exp_done[i] = '0; exp_busy[i] = 1'b0;
            res_set[i] = 1'b0; res_val[i] = '0;
        end
        forever begin
            @(posedge clk);
            e++;
            if (e < MAXC - 3) begin
                if (rst) begin
                    seen_rst    = 1'b1;
                    exp_gnt[e]  = '0;
                    exp_done[e] = '0;
                    exp_busy[e] = 1'b0;
                    res_set[e]  = 1'b1;
                    res_val[e]  = '0;
                    ptr         = 0;
                    free_at     = e + 1;
                end else if (seen_rst && e >= free_at && req != '0) begin
                    win = -1;
                    for (int k = 0; k < N; k++) begin
                        if (win < 0 && req[(ptr + k) % N]) win = (ptr + k) % N;
                    end
                    oh = '0;
                    oh[win] = 1'b1;
                    exp_gnt[e]    = oh;
                    exp_busy[e]   = 1'b1;
                    exp_gnt[e+1]  = oh;
                    exp_done[e+1] = oh;
                    exp_busy[e+1] = 1'b1;
                    res_set[e+1]  = 1'b1;
                    res_val[e+1]  = lu(op[2*win +: 2], a[W*win +: W], b[W*win +: W]);
                    free_at = e + 3;
                    ptr     = (win + 1) % N;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (seen_rst && e < MAXC) begin
            if (res_set[e]) cur_res = res_val[e];
            check("gnt",    64'(gnt),    64'(exp_gnt[e]));
            check("done",   64'(done),   64'(exp_done[e]));
            check("busy",   64'(busy),   64'(exp_busy[e]));
            check("result", 64'(result), 64'(cur_res));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_slice(input int i, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op[2*i +: 2] = o;
        a[W*i +: W]  = x;
        b[W*i +: W]  = y;
    endtask

    // One isolated request with hand-computed expected result.
    task automatic run_op(input int i, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] expr, input string name);
        logic [N-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        set_slice(i, o, x, y);
        req[i] = 1'b1;
        tick();
        check({name, "_gnt"}, 64'(gnt), 64'(oh));
        tick();
        check({name, "_done"}, 64'(done), 64'(oh));
        check({name, "_res"}, 64'(result), 64'(expr));
        req[i] = 1'b0;
        tick();
    endtask

    initial begin : stim
        int order [5];
        int when  [5];
        int ndone;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req = 4'b1111;
        op  = '0;
        a   = '0;
        b   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_gnt",    64'(gnt),    64'(0));
        check("rst_done",   64'(done),   64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_busy",   64'(busy),   64'(0));
        req = '0;
        tick();

        run_op(0, 2'b00, 8'hA5, 8'h00, 8'h5A, "not0");
        run_op(2, 2'b01, 8'hF0, 8'h3C, 8'h30, "and2");
        run_op(2, 2'b10, 8'hF0, 8'h3C, 8'hFC, "or2");
        run_op(2, 2'b11, 8'hF0, 8'h3C, 8'hCC, "xor2");
        check("hold_result", 64'(result), 64'(8'hCC));
        check("idle_busy",   64'(busy),   64'(0));

        // Simultaneous requests from 1 and 2 with pointer at 0.
        do_reset();
        set_slice(1, 2'b01, 8'h0F, 8'h33);
        set_slice(2, 2'b10, 8'h0F, 8'h30);
        req = 4'b0110;
        tick();
        check("sim_gnt1", 64'(gnt), 64'(4'b0010));
        tick();
        check("sim_res1", 64'(result), 64'(8'h03));
        req = 4'b0100;
        tick();
        tick();
        check("sim_gnt2", 64'(gnt), 64'(4'b0100));
        tick();
        check("sim_res2", 64'(result), 64'(8'h3F));
        req = '0;
        tick();

        // Fairness with all requesters held.
        do_reset();
        ndone = 0;
        req   = 4'b1111;
        for (int c = 0; c < 40 && ndone < 5; c++) begin
            tick();
            req = 4'b1111;
            if (done != '0) begin
                for (int j = 0; j < N; j++) if (done[j]) order[ndone] = j;
                when[ndone] = c;
                ndone++;
                req = 4'b1111 & ~done;
            end
        end
        req = '0;
        check("fair_count", 64'(ndone), 64'(5));
        for (int k = 0; k < 5; k++) begin
            if (k < ndone) check("fair_order", 64'(order[k]), 64'(exp_order[k]));
            if (k > 0 && k < ndone) check("fair_gap", 64'(when[k] - when[k-1]), 64'(3));
        end
        tick();

        // Reset during EXEC aborts without a done pulse.
        set_slice(0, 2'b11, 8'h55, 8'hFF);
        req = 4'b0001;
        tick();
        check("abort_gnt", 64'(gnt), 64'(4'b0001));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        check("abort_done", 64'(done), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        tick();
        check("abort_done2", 64'(done), 64'(0));

        // Operand changes after the grant are ignored.
        set_slice(1, 2'b00, 8'h0F, 8'h00);
        req = 4'b0010;
        tick();
        set_slice(1, 2'b11, 8'hFF, 8'hAA);
        tick();
        check("hold_a1", 64'(result), 64'(8'hF0));
        req = '0;
        tick();

`ifdef ARB_STATS_EN
        do_reset();
        run_op(0, 2'b01, 8'hFF, 8'h81, 8'h81, "st0a");
        run_op(0, 2'b10, 8'h10, 8'h01, 8'h11, "st0b");
        run_op(0, 2'b11, 8'hFF, 8'h0F, 8'hF0, "st0c");
        run_op(3, 2'b00, 8'h00, 8'h00, 8'hFF, "st3");
        check("cnt0", 64'(grant_cnt[15:0]),  64'(3));
        check("cnt1", 64'(grant_cnt[31:16]), 64'(0));
        check("cnt2", 64'(grant_cnt[47:32]), 64'(0));
        check("cnt3", 64'(grant_cnt[63:48]), 64'(1));
`endif

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
